// File: rtl/load_store_unit.sv
// Load/store initiator for the byte-lane data memory: checks each request,
// drives one memory access cycle, and returns a tagged, error-coded result.
module load_store_unit #(
  parameter int MEM_BYTES = 4096
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [2:0]  i_req_op,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [4:0]  i_req_rd,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic [4:0]  o_rsp_rd,
  output logic [1:0]  o_rsp_err,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_wr_data,
  output logic [1:0]  o_mem_wr_mask,
  output logic [2:0]  o_mem_rd_mask,
  input  logic [31:0] i_mem_rd_data,
  input  logic        i_mem_err_address_misaligned,
  input  logic        i_mem_err_invalid_read_mask
);

  // state | meaning
  // IDLE  | ready for a request
  // ISSUE | memory address/masks driven, sampled at end of cycle
  // WAIT  | memory read data and error flags captured
  // RESP  | response held until writeback accepts it
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic [31:0] rsp_data_q;
  logic [1:0]  rsp_err_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_wr_data_q;

  logic accept, is_word, is_half, misaligned, out_of_range;

  assign o_req_ready  = (state == IDLE) && i_reset;
  assign accept       = i_req_valid && o_req_ready;
  assign is_word      = (i_req_op == 3'd2) || (i_req_op == 3'd7);
  assign is_half      = (i_req_op == 3'd1) || (i_req_op == 3'd4) || (i_req_op == 3'd6);
  assign misaligned   = (is_word && (i_req_addr[1:0] != 2'b00)) || (is_half && i_req_addr[0]);
  assign out_of_range = i_req_addr >= 32'(MEM_BYTES);

  assign o_rsp_valid   = (state == RESP);
  assign o_rsp_data    = rsp_data_q;
  assign o_rsp_rd      = rd_q;
  assign o_rsp_err     = rsp_err_q;
  assign o_mem_address = mem_address_q;
  assign o_mem_wr_data = mem_wr_data_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  // Masks are only non-idle in ISSUE so the memory never sees a spurious write.
  always_comb begin
    state_nxt     = state;
    o_mem_wr_mask = 2'd0;
    o_mem_rd_mask = 3'd5;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (misaligned || out_of_range) ? RESP : ISSUE;
      end
      ISSUE: begin
        case (op_q)
          3'd0:    o_mem_rd_mask = 3'd4;
          3'd1:    o_mem_rd_mask = 3'd3;
          3'd2:    o_mem_rd_mask = 3'd0;
          3'd3:    o_mem_rd_mask = 3'd2;
          3'd4:    o_mem_rd_mask = 3'd1;
          3'd5:    o_mem_wr_mask = 2'd1;
          3'd6:    o_mem_wr_mask = 2'd2;
          default: o_mem_wr_mask = 2'd3;
        endcase
        state_nxt = WAIT;
      end
      WAIT:    state_nxt = RESP;
      RESP:    if (i_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      op_q          <= 3'd0;
      rd_q          <= 5'd0;
      rsp_data_q    <= 32'd0;
      rsp_err_q     <= 2'd0;
      mem_address_q <= 32'd0;
      mem_wr_data_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q       <= i_req_op;
            rd_q       <= i_req_rd;
            rsp_data_q <= 32'd0;
            if (misaligned)        rsp_err_q <= 2'd1;
            else if (out_of_range) rsp_err_q <= 2'd2;
            else begin
              rsp_err_q     <= 2'd0;
              // Memory-side address/data only change for requests that reach memory.
              mem_address_q <= i_req_addr;
              mem_wr_data_q <= i_req_wdata;
            end
          end
        end
        WAIT: begin
          rsp_data_q <= (op_q <= 3'd4) ? i_mem_rd_data : 32'd0;
          rsp_err_q  <= (i_mem_err_address_misaligned || i_mem_err_invalid_read_mask) ? 2'd3 : 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-lane memory model and a
// response scoreboard.
module tb_load_store_unit;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [2:0]  i_req_op = 3'd0;
  logic [31:0] i_req_addr = 32'd0;
  logic [31:0] i_req_wdata = 32'd0;
  logic [4:0]  i_req_rd = 5'd0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_data;
  logic [4:0]  o_rsp_rd;
  logic [1:0]  o_rsp_err;
  logic [31:0] o_mem_address;
  logic [31:0] o_mem_wr_data;
  logic [1:0]  o_mem_wr_mask;
  logic [2:0]  o_mem_rd_mask;
  logic [31:0] i_mem_rd_data = 32'd0;
  logic        i_mem_err_address_misaligned = 1'b0;
  logic        i_mem_err_invalid_read_mask = 1'b0;

  int checks = 0;
  int failures = 0;
  logic err_inject = 1'b0;
  logic [38:0] exp_q[$];   // {data, rd, err}

  load_store_unit #(.MEM_BYTES(4096)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_op(i_req_op), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_rd(i_req_rd),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_rd(o_rsp_rd), .o_rsp_err(o_rsp_err),
    .o_mem_address(o_mem_address), .o_mem_wr_data(o_mem_wr_data),
    .o_mem_wr_mask(o_mem_wr_mask), .o_mem_rd_mask(o_mem_rd_mask),
    .i_mem_rd_data(i_mem_rd_data),
    .i_mem_err_address_misaligned(i_mem_err_address_misaligned),
    .i_mem_err_invalid_read_mask(i_mem_err_invalid_read_mask)
  );

  always #5 i_clk = ~i_clk;

  // Byte-lane memory: registered read with extension selected by the read mask.
  logic [7:0] mem [4096];
  always @(posedge i_clk) begin
    logic [11:0] a;
    a = o_mem_address[11:0];
    case (o_mem_wr_mask)
      2'd1: mem[a] <= o_mem_wr_data[7:0];
      2'd2: begin mem[a] <= o_mem_wr_data[7:0]; mem[a+12'd1] <= o_mem_wr_data[15:8]; end
      2'd3: begin
        mem[a] <= o_mem_wr_data[7:0];         mem[a+12'd1] <= o_mem_wr_data[15:8];
        mem[a+12'd2] <= o_mem_wr_data[23:16]; mem[a+12'd3] <= o_mem_wr_data[31:24];
      end
      default: ;
    endcase
    case (o_mem_rd_mask)
      3'd0: i_mem_rd_data <= {mem[a+12'd3], mem[a+12'd2], mem[a+12'd1], mem[a]};
      3'd1: i_mem_rd_data <= {16'd0, mem[a+12'd1], mem[a]};
      3'd2: i_mem_rd_data <= {24'd0, mem[a]};
      3'd3: i_mem_rd_data <= {{16{mem[a+12'd1][7]}}, mem[a+12'd1], mem[a]};
      3'd4: i_mem_rd_data <= {{24{mem[a][7]}}, mem[a]};
      default: ;
    endcase
    i_mem_err_address_misaligned <= err_inject && ((o_mem_rd_mask != 3'd5) || (o_mem_wr_mask != 2'd0));
    i_mem_err_invalid_read_mask  <= (o_mem_rd_mask > 3'd5);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_rd_mask(input logic [2:0] op);
    case (op)
      3'd0: return 3'd4;
      3'd1: return 3'd3;
      3'd2: return 3'd0;
      3'd3: return 3'd2;
      3'd4: return 3'd1;
      default: return 3'd5;
    endcase
  endfunction

  function automatic logic [1:0] exp_wr_mask(input logic [2:0] op);
    case (op)
      3'd5: return 2'd1;
      3'd6: return 2'd2;
      3'd7: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic do_req(input string tag, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input logic [31:0] exp_data, input logic [1:0] exp_err, input int hold);
    int lat = 0;
    int wr_cyc = 0;
    int rd_cyc = 0;
    logic [1:0] wm_seen = 2'd0;
    logic [2:0] rm_seen = 3'd5;
    logic goes_to_mem = (exp_err == 2'd0) || (exp_err == 2'd3);
    logic stable = 1'b1;
    logic [31:0] d0;
    logic [4:0] r0;
    logic [1:0] e0;
    logic [38:0] exp;
    exp_q.push_back({exp_data, rd, exp_err});
    @(negedge i_clk);
    check({tag, "_ready"}, 32'(o_req_ready), 32'd1);
    i_req_valid = 1'b1; i_req_op = op; i_req_addr = addr; i_req_wdata = wdata; i_req_rd = rd;
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    while (1) begin
      @(negedge i_clk);
      lat++;
      if (o_mem_wr_mask != 2'd0) begin wr_cyc++; wm_seen = o_mem_wr_mask; end
      if (o_mem_rd_mask != 3'd5) begin rd_cyc++; rm_seen = o_mem_rd_mask; end
      if (o_rsp_valid || lat >= 20) break;
    end
    check({tag, "_latency"}, 32'(lat), goes_to_mem ? 32'd3 : 32'd1);
    check({tag, "_wr_mask"}, {wr_cyc[29:0], wm_seen},
          goes_to_mem && op >= 3'd5 ? {30'd1, exp_wr_mask(op)} : 32'd0);
    check({tag, "_rd_mask"}, {rd_cyc[28:0], rm_seen},
          goes_to_mem && op <= 3'd4 ? {29'd1, exp_rd_mask(op)} : {29'd0, 3'd5});
    d0 = o_rsp_data; r0 = o_rsp_rd; e0 = o_rsp_err;
    for (int i = 0; i < hold; i++) begin
      i_req_valid = 1'b1; i_req_op = 3'd7; i_req_addr = 32'h20; i_req_wdata = 32'h5555_5555;
      @(negedge i_clk);
      if (!o_rsp_valid || o_rsp_data !== d0 || o_rsp_rd !== r0 || o_rsp_err !== e0 || o_req_ready !== 1'b0)
        stable = 1'b0;
    end
    if (hold > 0) check({tag, "_hold_stable"}, 32'(stable), 32'd1);
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b1;
    if (exp_q.size() == 0) check({tag, "_queue"}, 32'd0, 32'd1);
    else begin
      exp = exp_q.pop_front();
      check({tag, "_data"}, o_rsp_data, exp[38:7]);
      check({tag, "_rd"}, 32'(o_rsp_rd), 32'(exp[6:2]));
      check({tag, "_err"}, 32'(o_rsp_err), 32'(exp[1:0]));
    end
    @(posedge i_clk);
    #1 i_rsp_ready = 1'b0;
    @(negedge i_clk);
    check({tag, "_back_idle"}, {31'd0, o_rsp_valid}, 32'd0);
  endtask

  initial begin
    logic quiet;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    #2;
    check("rst_ready", 32'(o_req_ready), 32'd0);
    check("rst_rd_mask", 32'(o_mem_rd_mask), 32'd5);
    #20 i_reset = 1'b1;

    do_req("sw",       3'd7, 32'h10, 32'hDEAD_BEEF, 5'd1, 32'd0,          2'd0, 0);
    do_req("lw",       3'd2, 32'h10, 32'd0,         5'd2, 32'hDEAD_BEEF,  2'd0, 0);
    do_req("lb",       3'd0, 32'h13, 32'd0,         5'd3, 32'hFFFF_FFDE,  2'd0, 0);
    do_req("lbu",      3'd3, 32'h13, 32'd0,         5'd4, 32'h0000_00DE,  2'd0, 0);
    do_req("lh",       3'd1, 32'h12, 32'd0,         5'd5, 32'hFFFF_DEAD,  2'd0, 0);
    do_req("lhu",      3'd4, 32'h10, 32'd0,         5'd6, 32'h0000_BEEF,  2'd0, 0);
    do_req("sb",       3'd5, 32'h11, 32'h77,        5'd8, 32'd0,          2'd0, 0);
    do_req("lw_sb",    3'd2, 32'h10, 32'd0,         5'd9, 32'hDEAD_77EF,  2'd0, 0);
    do_req("sh_mis",   3'd6, 32'h11, 32'hAAAA,      5'd7, 32'd0,          2'd1, 0);
    do_req("lw_post",  3'd2, 32'h10, 32'd0,         5'd10, 32'hDEAD_77EF, 2'd0, 0);
    do_req("lw_oor",   3'd2, 32'h1000, 32'd0,       5'd11, 32'd0,         2'd2, 0);
    do_req("lw_prio",  3'd2, 32'h1002, 32'd0,       5'd12, 32'd0,         2'd1, 0);
    do_req("sw_top",   3'd7, 32'hFFC, 32'h0123_4567, 5'd13, 32'd0,        2'd0, 0);
    do_req("lh_top",   3'd1, 32'hFFE, 32'd0,        5'd14, 32'h0000_0123, 2'd0, 0);
    do_req("lw_stall", 3'd2, 32'h10, 32'd0,         5'd15, 32'hDEAD_77EF, 2'd0, 5);
    do_req("sw_after", 3'd7, 32'h20, 32'hCAFE_F00D, 5'd16, 32'd0,         2'd0, 0);
    do_req("lw_after", 3'd2, 32'h20, 32'd0,         5'd17, 32'hCAFE_F00D, 2'd0, 0);
    err_inject = 1'b1;
    do_req("lw_memerr", 3'd2, 32'h10, 32'd0,        5'd18, 32'hDEAD_77EF, 2'd3, 0);
    err_inject = 1'b0;

    // Reset during WAIT: no clock edge between asserting reset and checking.
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_op = 3'd2; i_req_addr = 32'h20; i_req_wdata = 32'h1234_5678; i_req_rd = 5'd19;
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    #1 i_reset = 1'b0;
    #1;
    check("arst_ready",   32'(o_req_ready), 32'd0);
    check("arst_valid",   32'(o_rsp_valid), 32'd0);
    check("arst_data",    o_rsp_data, 32'd0);
    check("arst_rd_err",  {25'd0, o_rsp_rd, o_rsp_err}, 32'd0);
    check("arst_addr",    o_mem_address, 32'd0);
    check("arst_wdata",   o_mem_wr_data, 32'd0);
    check("arst_masks",   {27'd0, o_mem_wr_mask, o_mem_rd_mask}, 32'd5);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("arst_release_ready", 32'(o_req_ready), 32'd1);
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      if (o_rsp_valid !== 1'b0) quiet = 1'b0;
    end
    check("arst_no_stale_rsp", 32'(quiet), 32'd1);
    do_req("lw_post_rst", 3'd2, 32'h20, 32'd0, 5'd20, 32'hCAFE_F00D, 2'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the data memory port. Accepts one load/store request at a time from the execute stage over a valid/ready handshake and checks alignment and address range. It then drives the byte-lane memory's address, write-mask and read-mask inputs, captures the registered read data one cycle later, and returns a tagged result and error code to writeback over a second valid/ready handshake.

Parameters:
MEM_BYTES, 4096, size of the memory in bytes; any address >= MEM_BYTES is out of range.

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  asynchronous, active-low reset
i_req_valid  input  1  request valid
o_req_ready  output  1  LSU can accept a request
i_req_op  input  3  0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW
i_req_addr  input  32  byte address
i_req_wdata  input  32  store data, unshifted (low bits used)
i_req_rd  input  5  destination register tag, echoed back
o_rsp_valid  output  1  response valid
i_rsp_ready  input  1  writeback accepts the response
o_rsp_data  output  32  load result, already extended; 0 for stores
o_rsp_rd  output  5  echoed tag
o_rsp_err  output  2  0 ok, 1 misaligned, 2 out of range, 3 memory-reported error
o_mem_address  output  32  memory byte address
o_mem_wr_data  output  32  memory write data
o_mem_wr_mask  output  2  0 none, 1 byte, 2 half, 3 word
o_mem_rd_mask  output  3  0 W, 1 HZ, 2 BZ, 3 HE, 4 BE, 5 none
i_mem_rd_data  input  32  read data, registered in memory, valid one cycle after the sampling edge
i_mem_err_address_misaligned  input  1  memory error flag, registered in memory
i_mem_err_invalid_read_mask  input  1  memory error flag, registered in memory

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset: i_reset low, asynchronously. State goes to IDLE and all latched request registers clear.
  - Outputs while in reset: o_req_ready=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_rd=0, o_rsp_err=0, o_mem_address=0, o_mem_wr_data=0, o_mem_wr_mask=0, o_mem_rd_mask=5.
  - Reset mid-operation drops the pending request and produces no response.
- o_req_ready = (state==IDLE) && i_reset.
- IDLE, on accept (i_req_valid && o_req_ready): latch op, addr, wdata and rd, then run the checks.
  - Misaligned: word op with addr[1:0]!=0, or half op with addr[0]!=0. Set err=1 and go to RESP.
  - Else out of range: addr >= MEM_BYTES. Set err=2 and go to RESP.
  - Misaligned takes priority over out of range.
  - Else go to ISSUE.
- ISSUE, one cycle:
  - o_mem_address = latched addr; o_mem_wr_data = latched wdata.
  - Loads: wr_mask=0; rd_mask is LB->4, LH->3, LW->0, LBU->2, LHU->1.
  - Stores: rd_mask=5; wr_mask is SB->1, SH->2, SW->3.
  - Memory samples these at the end of ISSUE. Go to WAIT.
- Outside ISSUE: o_mem_wr_mask=0 and o_mem_rd_mask=5 at all times, so there are no spurious writes. o_mem_address and o_mem_wr_data hold their last value.
- WAIT, one cycle:
  - Capture o_rsp_data: i_mem_rd_data for loads, 0 for stores.
  - err=3 if either memory error flag is set, else 0. Go to RESP.
- RESP: o_rsp_valid=1 with data, rd and err held stable until i_rsp_ready. On the handshake go to IDLE. A new request cannot be accepted in the handshake cycle.
- Latency, accept edge T to o_rsp_valid:
  - Normal access: 3 cycles (ISSUE at T+1, WAIT at T+2, RESP at T+3).
  - Rejected request (err 1 or 2): 1 cycle, with no memory access.
- Throughput: one request per 4 cycles at best.
- Rejected requests return o_rsp_data=0.
- i_req_* are ignored outside IDLE.

Test Plan:
- SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> o_rsp_data=0xDEADBEEF, err=0, o_rsp_valid exactly 3 cycles after each accept; o_mem_wr_mask=3 only in the SW ISSUE cycle.
- After the SW above:
  - LB 0x13 -> 0xFFFFFFDE
  - LBU 0x13 -> 0x000000DE
  - LH 0x12 -> 0xFFFFDEAD
  - LHU 0x10 -> 0x0000BEEF
  - SB 0x11 wdata 0x77, then LW 0x10 -> 0xDEAD77EF
- SH 0x11 rd=7 -> response 1 cycle after accept with err=1, rd=7, data=0; o_mem_wr_mask stays 0 throughout; a following LW 0x10 is unchanged.
- LW 0x1000 (MEM_BYTES=4096) -> err=2, no ISSUE cycle, o_mem_rd_mask stays 5. LW 0x1002 -> err=1 (misaligned has priority).
- LW with i_rsp_ready held low 5 cycles -> o_rsp_valid, data and rd stable, o_req_ready=0, a new i_req_valid is not accepted; accepted only after the response handshake and return to IDLE.
- i_reset pulled low during WAIT -> outputs take reset values immediately, without a clock edge; after release o_req_ready=1 and no stale response ever appears.
